// File: rtl/dmem_sram_ctrl.sv
// dmem_sram_ctrl: data-side SRAM access controller downstream of the MEM stage.
// Issues loads/stores to a synchronous data SRAM, stalls the pipeline for the
// read latency and holds the returned word until the pipeline advances, so a
// load is never issued twice.
//
// Optional feature: define DMEM_ADDR_MAP_EN for the fixed kseg0/kseg1 address
// translation (0x8000_0000-0xBFFF_FFFF -> top three bits cleared).
//
// Ports:
//   clk, rst            pipeline clock, synchronous active-high reset
//   mem_ce_i/we_i       access request / 1 = store
//   mem_sel_i           byte enables (0000 on loads)
//   mem_addr_i          virtual byte address
//   mem_wdata_i         byte-replicated store data
//   flush_i             kills the current access
//   pipe_stall_i        stall from other sources
//   mem_rdata_o         load data to the MEM stage
//   stall_req_o         stall request for stages up to and including MEM
//   data_sram_*         synchronous SRAM interface
module dmem_sram_ctrl #(
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_ce_i,
  input  logic        mem_we_i,
  input  logic [3:0]  mem_sel_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_wdata_i,
  input  logic        flush_i,
  input  logic        pipe_stall_i,
  output logic [31:0] mem_rdata_o,
  output logic        stall_req_o,
  output logic        data_sram_en,
  output logic [3:0]  data_sram_wen,
  output logic [31:0] data_sram_addr,
  output logic [31:0] data_sram_wdata,
  input  logic [31:0] data_sram_rdata
);

  localparam int unsigned CNT_W  = 2;
  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    RD_DONE = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q,   cnt_d;
  logic [DATA_W-1:0]   rbuf_q,  rbuf_d;
  logic [DATA_W-1:0]   phys_addr;

  // Virtual-to-physical address mapping
`ifdef DMEM_ADDR_MAP_EN
  always_comb begin
    phys_addr = mem_addr_i;
    if (mem_addr_i[31:29] == 3'b100 || mem_addr_i[31:29] == 3'b101) begin
      phys_addr = {3'b000, mem_addr_i[28:0]};
    end
  end
`else
  assign phys_addr = mem_addr_i;
`endif

  // State, latency counter and read buffer
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rbuf_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rbuf_q  <= rbuf_d;
    end
  end

  // Next-state and outputs; everything is forced to zero while rst is high
  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    rbuf_d          = rbuf_q;
    data_sram_en    = 1'b0;
    data_sram_wen   = 4'b0000;
    data_sram_addr  = '0;
    data_sram_wdata = '0;
    stall_req_o     = 1'b0;
    mem_rdata_o     = '0;

    if (!rst) begin
      case (state_q)
        IDLE: begin
          if (mem_ce_i && !flush_i) begin
            data_sram_en   = 1'b1;
            data_sram_addr = phys_addr;
            if (mem_we_i) begin
              data_sram_wen   = mem_sel_i;
              data_sram_wdata = mem_wdata_i;
            end else begin
              stall_req_o = 1'b1;
              cnt_d       = CNT_W'(READ_LATENCY - 1);
              state_d     = RD_WAIT;
            end
          end
        end

        RD_WAIT: begin
          if (flush_i) begin
            state_d = IDLE;
          end else begin
            stall_req_o = 1'b1;
            if (cnt_q == '0) begin
              rbuf_d  = data_sram_rdata;
              state_d = RD_DONE;
            end else begin
              cnt_d = cnt_q - CNT_W'(1);
            end
          end
        end

        RD_DONE: begin
          // Word is held here until the pipeline actually advances
          mem_rdata_o = rbuf_q;
          if (flush_i || !pipe_stall_i) begin
            state_d = IDLE;
          end
        end

        default: state_d = IDLE;
      endcase
    end
  end

endmodule
